mux_arbiter_4: RTL and testbench

MUX_ARBITER_4 -- requirements
Module: mux_arbiter4

---
 rtl/mux_arbiter_4.sv | 123 ++++++++++++
 tb/tb_mux_arbiter_4.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter_4.sv
// mux_arbiter_4: four-requester round-robin arbiter with a registered output word.
//
// A requester raises its req bit with its data valid; the arbiter answers with a
// combinational one-hot ack and captures the winning word into out at the next
// rising edge. The output side is a valid/ready handshake. A new word can be
// captured in the same cycle the held word is taken, giving one word per cycle.
//
// Ports:
//   clk     - single clock, rising edge
//   rst_n   - asynchronous active-low reset
//   req     - request flags, bit i = requester i (0=a, 1=b, 2=c, 3=d)
//   a..d    - requester data, valid while the matching req bit is high
//   ack     - combinational one-hot accept strobe
//   out     - registered granted word
//   select  - registered one-hot source of out, 0 when no word is held
//   valid   - out holds an undelivered word
//   ready   - consumer accepts out on an edge where valid is high
module mux_arbiter_4 #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            req,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] c,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [3:0]            ack,
  output logic [DATA_WIDTH-1:0] out,
  output logic [3:0]            select,
  output logic                  valid,
  input  logic                  ready
);

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StHold = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              last_q, last_d;
  logic [DATA_WIDTH-1:0]   out_q, out_d;
  logic [3:0]              select_q, select_d;

  logic                    grant_opp;
  logic                    found;
  logic [1:0]              grant_idx;
  logic [DATA_WIDTH-1:0]   grant_data;

  // A slot is free when nothing is held, or the held word leaves on this edge.
  assign grant_opp = (state_q == StIdle) || ready;

  // Search order last+1, last+2, last+3, last; the first requester found wins,
  // so the most recent winner always has lowest priority.
  always_comb begin
    found     = 1'b0;
    grant_idx = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      logic [1:0] idx;
      idx = last_q + 2'(k);
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_comb begin
    grant_data = a;
    unique case (grant_idx)
      2'd0: grant_data = a;
      2'd1: grant_data = b;
      2'd2: grant_data = c;
      2'd3: grant_data = d;
      default: grant_data = a;
    endcase
  end

  // Gated by rst_n so ack drops immediately when reset asserts.
  always_comb begin
    ack = 4'b0000;
    if (rst_n && grant_opp && found) begin
      ack = 4'b0001 << grant_idx;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    out_d    = out_q;
    select_d = select_q;
    if (ack != 4'b0000) begin
      // Covers both a fresh grant from idle and a back-to-back capture.
      state_d  = StHold;
      last_d   = grant_idx;
      out_d    = grant_data;
      select_d = ack;
    end else if (state_q == StHold && ready) begin
      // Word delivered with nobody waiting; out keeps its last value.
      state_d  = StIdle;
      select_d = 4'b0000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      last_q   <= 2'd3;
      out_q    <= '0;
      select_q <= 4'b0000;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      out_q    <= out_d;
      select_q <= select_d;
    end
  end

  assign out    = out_q;
  assign select = select_q;
  assign valid  = (state_q == StHold);

endmodule

// File: tb/tb_mux_arbiter_4.sv
// Bench for mux_arbiter_4: directed vectors drive the requesters and check ack;
// each expected grant pushes {word, select} into a queue, and a monitor pops and
// compares it whenever the DUT presents valid with ready high.
module tb_mux_arbiter_4;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req;
  logic [DW-1:0] a, b, c, d;
  logic [3:0]    ack;
  logic [DW-1:0] out;
  logic [3:0]    select;
  logic          valid;
  logic          ready;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW+3:0] exp_q[$];

  mux_arbiter_4 #(.DATA_WIDTH(DW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .a      (a),
    .b      (b),
    .c      (c),
    .d      (d),
    .ack    (ack),
    .out    (out),
    .select (select),
    .valid  (valid),
    .ready  (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive inputs for this cycle, then check the combinational ack.
  task automatic cyc(input logic [3:0] r, input logic rdy, input logic [3:0] exp_ack,
                     input logic [DW-1:0] exp_word);
    step();
    req   = r;
    ready = rdy;
    #1;
    check("ack", 64'(ack), 64'(exp_ack));
    if (exp_ack != 4'b0000) exp_q.push_back({exp_word, exp_ack});
  endtask

  // Monitor: a transfer completes at the coming rising edge.
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_word: got out=0x%0h sel=0x%0h, want none", out, select);
      end else begin
        logic [DW+3:0] e;
        e = exp_q.pop_front();
        check("out", 64'(out), 64'(e[DW+3:4]));
        check("select", 64'(select), 64'(e[3:0]));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'hF;
    ready = 1'b1;
    a = 32'hA0; b = 32'hB0; c = 32'hC0; d = 32'hD0;
    #12;
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_select", 64'(select), 64'd0);
    check("rst_out", 64'(out), 64'd0);
    check("rst_ack", 64'(ack), 64'd0);

    // Rotation through all four with ready held; release takes effect at once.
    step();
    rst_n = 1'b1;
    #1;
    check("rr_ack0", 64'(ack), 64'h1);
    exp_q.push_back({32'hA0, 4'h1});
    cyc(4'hF, 1'b1, 4'h2, 32'hB0);
    check("rr_valid", 64'(valid), 64'd1);
    cyc(4'hF, 1'b1, 4'h4, 32'hC0);
    cyc(4'hF, 1'b1, 4'h8, 32'hD0);
    cyc(4'hF, 1'b1, 4'h1, 32'hA0);
    check("rr_valid_cont", 64'(valid), 64'd1);
    cyc(4'h0, 1'b1, 4'h0, '0);
    cyc(4'h0, 1'b1, 4'h0, '0);
    check("rr_drain_valid", 64'(valid), 64'd0);

    // Stall: one grant to c, held while ready is low, req changes ignored.
    c = 32'h12345678;
    cyc(4'h4, 1'b0, 4'h4, 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      cyc(4'hB, 1'b0, 4'h0, '0);
      check("stall_valid", 64'(valid), 64'd1);
      check("stall_select", 64'(select), 64'h4);
      check("stall_out", 64'(out), 64'h12345678);
    end
    cyc(4'h0, 1'b1, 4'h0, '0);
    cyc(4'h0, 1'b1, 4'h0, '0);
    check("stall_end_valid", 64'(valid), 64'd0);
    check("stall_end_select", 64'(select), 64'h0);
    check("stall_end_out", 64'(out), 64'h12345678);

    // After b wins, a beats b; then b again.
    a = 32'h11; b = 32'h22;
    cyc(4'h2, 1'b1, 4'h2, 32'h22);
    cyc(4'h3, 1'b1, 4'h1, 32'h11);
    cyc(4'h2, 1'b1, 4'h2, 32'h22);
    cyc(4'h0, 1'b1, 4'h0, '0);
    cyc(4'h0, 1'b1, 4'h0, '0);

    // Idle with ready toggling.
    for (int i = 0; i < 10; i++) begin
      cyc(4'h0, 1'(i % 2), 4'h0, '0);
      check("idle_valid", 64'(valid), 64'd0);
      check("idle_select", 64'(select), 64'h0);
    end

    // Single requester d held: granted every cycle, out follows d one cycle late.
    for (int i = 0; i < 4; i++) begin
      step();
      d     = 32'h100 + 32'(i);
      req   = 4'h8;
      ready = 1'b1;
      #1;
      check("d_ack", 64'(ack), 64'h8);
      exp_q.push_back({32'h100 + 32'(i), 4'h8});
    end
    cyc(4'h0, 1'b1, 4'h0, '0);
    cyc(4'h0, 1'b1, 4'h0, '0);

    // Reset mid-hold discards the word; pointer returns to its reset value.
    d = 32'hD0; b = 32'hB0;
    cyc(4'h8, 1'b0, 4'h8, 32'hD0);
    cyc(4'h0, 1'b0, 4'h0, '0);
    check("hold_select", 64'(select), 64'h8);
    check("hold_valid", 64'(valid), 64'd1);
    rst_n = 1'b0;
    req   = 4'hA;
    #1;
    exp_q.delete();
    check("arst_valid", 64'(valid), 64'd0);
    check("arst_select", 64'(select), 64'h0);
    check("arst_out", 64'(out), 64'h0);
    check("arst_ack", 64'(ack), 64'h0);
    step();
    rst_n = 1'b1;
    ready = 1'b1;
    #1;
    check("post_rst_ack", 64'(ack), 64'h2);
    exp_q.push_back({32'hB0, 4'h2});
    cyc(4'h8, 1'b1, 4'h8, 32'hD0);
    cyc(4'h0, 1'b1, 4'h0, '0);
    cyc(4'h0, 1'b1, 4'h0, '0);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover_words: got %0d pending, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
